// File: rtl/shift_left_right_pkg.sv
// Shared multiplier constants and the shift-direction type used by the
// operand shifters and the product register.
package shift_left_right_pkg;

  localparam int MULT_IN_W   = 8;
  localparam int MULT_LEFT_W = 14;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

endpackage : shift_left_right_pkg

// File: rtl/shift_left_right_shift_reg_lr.sv
// Generic W-bit shift register: zero-extending parallel load, one-position
// shift in direction DIR with zero fill, hold otherwise.
module shift_reg_lr
  import shift_left_right_pkg::*;
#(
  parameter int         W       = MULT_LEFT_W,
  parameter int         DATA_IN = MULT_IN_W,
  parameter shift_dir_e DIR     = SHIFT_LEFT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               shift_en_i,
  input  logic [DATA_IN-1:0] data_i,
  output logic [W-1:0]       data_o
);

  logic [W-1:0] data_q = '0;
  logic [W-1:0] data_d;

  // Load outranks shift; the shift operators discard the outgoing bit and fill with zero.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = W'(data_i);
    end else if (shift_en_i) begin
      if (DIR == SHIFT_LEFT) begin
        data_d = data_q << 1;
      end else begin
        data_d = data_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule : shift_reg_lr

// File: rtl/shift_left_right.sv
// Operand shifter pair for the shift-and-add multiplier: left shifter feeds
// the partial-product addend, right shifter feeds the step bit and done flag.
module shift_left_right
  import shift_left_right_pkg::*;
#(
  parameter int IN_W   = MULT_IN_W,
  parameter int LEFT_W = MULT_LEFT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   multiplier,
  input  logic [IN_W-1:0]   multiplicand,
  input  logic              shift_en,
  input  logic              load,
  output logic [LEFT_W-1:0] shifted_multiplier,
  output logic [IN_W-1:0]   shifted_multiplicand,
  output logic              lsb_multiplicand,
  output logic              zflag
);

  shift_reg_lr #(
    .W       (LEFT_W),
    .DATA_IN (IN_W),
    .DIR     (SHIFT_LEFT)
  ) u_left (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .shift_en_i (shift_en),
    .data_i     (multiplier),
    .data_o     (shifted_multiplier)
  );

  shift_reg_lr #(
    .W       (IN_W),
    .DATA_IN (IN_W),
    .DIR     (SHIFT_RIGHT)
  ) u_right (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .shift_en_i (shift_en),
    .data_i     (multiplicand),
    .data_o     (shifted_multiplicand)
  );

  // Flags follow the right register directly so the consumer sees them in the same cycle.
  assign lsb_multiplicand = shifted_multiplicand[0];
  assign zflag            = (shifted_multiplicand == '0);

endmodule : shift_left_right

// File: tb/tb_shift_left_right.sv
// Randomized and directed bench for shift_left_right against an arithmetic
// operand/step-count reference model.
module tb_shift_left_right;

  localparam int IN_W   = 8;
  localparam int LEFT_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [IN_W-1:0]   multiplier = '0;
  logic [IN_W-1:0]   multiplicand = '0;
  logic              shift_en = 1'b0;
  logic              load = 1'b0;
  logic [LEFT_W-1:0] shifted_multiplier;
  logic [IN_W-1:0]   shifted_multiplicand;
  logic              lsb_multiplicand;
  logic              zflag;

  int total = 0;
  int bad   = 0;

  // Reference model: operands captured at load plus number of shifts since.
  longint m_mul = 0;
  longint m_mcd = 0;
  int     m_k   = 0;

  shift_left_right #(
    .IN_W   (IN_W),
    .LEFT_W (LEFT_W)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .multiplier           (multiplier),
    .multiplicand         (multiplicand),
    .shift_en             (shift_en),
    .load                 (load),
    .shifted_multiplier   (shifted_multiplier),
    .shifted_multiplicand (shifted_multiplicand),
    .lsb_multiplicand     (lsb_multiplicand),
    .zflag                (zflag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint exp_left();
    if (m_k >= LEFT_W) return 0;
    return (m_mul * (64'd1 << m_k)) % (64'd1 << LEFT_W);
  endfunction

  function automatic longint exp_right();
    if (m_k >= IN_W) return 0;
    return m_mcd / (64'd1 << m_k);
  endfunction

  // Apply one cycle of inputs, advance the model, then check all outputs after the edge.
  task automatic step(input bit r, input bit ld, input bit en,
                      input logic [IN_W-1:0] mul, input logic [IN_W-1:0] mcd);
    longint er;
    rst = r; load = ld; shift_en = en; multiplier = mul; multiplicand = mcd;
    @(posedge clk);
    if (r) begin
      m_mul = 0; m_mcd = 0; m_k = 0;
    end else if (ld) begin
      m_mul = mul; m_mcd = mcd; m_k = 0;
    end else if (en) begin
      if (m_k < 64) m_k++;
    end
    #1;
    er = exp_right();
    chk("left",  longint'(shifted_multiplier), exp_left());
    chk("right", longint'(shifted_multiplicand), er);
    chk("lsb",   longint'(lsb_multiplicand), er % 2);
    chk("zflag", longint'(zflag), longint'(er == 0));
  endtask

  initial begin
    int lseq[7];
    int rseq[7];
    logic [LEFT_W-1:0] hold_l;
    logic [IN_W-1:0]   hold_r;
    lseq = '{32'h01FE, 32'h03FC, 32'h07F8, 32'h0FF0, 32'h1FE0, 32'h3FC0, 32'h3F80};
    rseq = '{32'h52, 32'h29, 32'h14, 32'h0A, 32'h05, 32'h02, 32'h01};

    @(posedge clk); #1;
    step(1, 0, 0, 8'h00, 8'h00);
    chk("rst_left", longint'(shifted_multiplier), 0);
    chk("rst_zflag", longint'(zflag), 1);

    step(0, 1, 0, 8'hFF, 8'hA5);
    chk("load_left", longint'(shifted_multiplier), 64'h00FF);
    chk("load_right", longint'(shifted_multiplicand), 64'hA5);
    chk("load_lsb", longint'(lsb_multiplicand), 1);
    chk("load_z", longint'(zflag), 0);

    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 8'h00, 8'h00);
      chk("seq_left", longint'(shifted_multiplier), lseq[i]);
      chk("seq_right", longint'(shifted_multiplicand), rseq[i]);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 8'h00, 8'h00);
      chk("drain_right", longint'(shifted_multiplicand), 0);
      chk("drain_z", longint'(zflag), 1);
    end

    step(0, 1, 1, 8'h03, 8'h06);
    chk("ld_wins_left", longint'(shifted_multiplier), 3);
    chk("ld_wins_right", longint'(shifted_multiplicand), 6);

    step(0, 0, 1, 8'h00, 8'h00);
    hold_l = shifted_multiplier;
    hold_r = shifted_multiplicand;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 8'h5A, 8'hC3);
      chk("hold_left", longint'(shifted_multiplier), longint'(hold_l));
      chk("hold_right", longint'(shifted_multiplicand), longint'(hold_r));
    end

    step(0, 1, 0, 8'hFF, 8'hA5);
    step(0, 0, 1, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    chk("pre_rst_right", longint'(shifted_multiplicand), 64'h29);
    step(1, 0, 1, 8'h00, 8'h00);
    chk("mid_rst_left", longint'(shifted_multiplier), 0);
    chk("mid_rst_right", longint'(shifted_multiplicand), 0);
    chk("mid_rst_z", longint'(zflag), 1);
    step(0, 1, 0, 8'h81, 8'h7E);
    chk("post_rst_left", longint'(shifted_multiplier), 64'h0081);
    chk("post_rst_right", longint'(shifted_multiplicand), 64'h7E);

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 3, (r >= 3) && (r < 18), $urandom_range(0, 99) < 65,
           IN_W'($urandom), IN_W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shift_left_right

// File: doc/shift_left_right.md
# shift_left_right

Operand shifter pair for the sequential 8x8 unsigned shift-and-add multiplier datapath. It holds two registers:
- a left-shifting, zero-extended multiplier register that supplies the partial-product addend;
- a right-shifting multiplicand register that supplies the per-step control bit and the done flag.

Both registers load together and advance in lock-step, one bit position per enabled clock.

## Interface

Clocking: one clock; reset is synchronous and active-high.

Parameters:
- IN_W, default 8: operand width.
- LEFT_W, default 14: left-shifter and partial-product width. Must be ≥ IN_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
- multiplier  input  IN_W  operand loaded into the left shifter.
- multiplicand  input  IN_W  operand loaded into the right shifter.
- shift_en  input  1  advance both shifters by one position.
- load  input  1  capture both operands (start of a multiplication).
- shifted_multiplier  output  LEFT_W  left-shifter register contents.
- shifted_multiplicand  output  IN_W  right-shifter register contents.
- lsb_multiplicand  output  1  shifted_multiplicand[0], combinational.
- zflag  output  1  high when shifted_multiplicand == 0, combinational.

## Operation

Per rising edge, priority order (highest first):
- rst=1: both registers ← 0.
- load=1: left ← multiplier zero-extended to LEFT_W; right ← multiplicand. shift_en is ignored.
- shift_en=1: left ← left << 1, zero into bit 0; bits leaving bit LEFT_W-1 are discarded (truncation, no saturation). Right ← right >> 1, zero into MSB; bit 0 is discarded.
- Otherwise both registers hold.

Width and flag rules:
- Shifting continues indefinitely. Once the right register reaches 0 it stays 0 and zflag stays high. The left register eventually becomes 0.
- Outputs are the register values directly; no output pipeline.
- At power-up, before the first rst, state is undefined. Simulation models initialize both registers to 0.

## Timing

- Reset: all outputs 0 and zflag=1 on the edge where rst=1. Reset mid-operation aborts immediately, with no partial shift.
- Load latency: operands are visible on the outputs one cycle after load is sampled high.
- Each shift_en-high edge moves both registers exactly one position.
- load and shift_en high together: load wins, and the shift is not applied that cycle.
- lsb_multiplicand and zflag follow the right register combinationally, in the same cycle it updates.
- For multiplier step k (k=0..IN_W-1, counted after load), shifted_multiplier = multiplier·2^k mod 2^LEFT_W, and lsb_multiplicand = multiplicand bit k.
- The consumer stops when zflag=1.

## Structure

- Shared multiplier package: IN_W=8 and LEFT_W=14 constants, also used by the product register.
- One sub-module, shift_reg_lr: a generic width-W shift register with parameter DIR (left/right) and parameter DATA_IN width, zero-extending on load.
- shift_left_right instantiates shift_reg_lr twice and adds the combinational zflag and lsb logic.

## Test plan

- Reset, then load with multiplier=0xFF, multiplicand=0xA5 → next cycle left=0x00FF, right=0xA5, lsb=1, zflag=0.
- Shift_en held high for 7 cycles after that load → left sequence 0x01FE, 0x03FC, 0x07F8, 0x0FF0, 0x1FE0, 0x3FC0, 0x3F80 (truncated); right sequence 0x52, 0x29, 0x14, 0x0A, 0x05, 0x02, 0x01.
- Continue one more shift → right=0x00, zflag=1. Further shifts keep right=0 and zflag=1.
- load=1 and shift_en=1 in the same cycle with multiplier=0x03, multiplicand=0x06 → left=0x0003, right=0x06 (no shift applied).
- shift_en=0 for 5 cycles mid-operation → both registers unchanged.
- rst=1 while shifting with right=0x29 → next edge left=0, right=0, zflag=1. A subsequent load works normally.
